// File: rtl/dqtz_level_decoder_pkg.sv
// rtl/dqtz_level_decoder_pkg.sv - shared constants and types for the level decoder
package dqtz_level_decoder_pkg;

    localparam int HV_DIM    = 1024;
    localparam int M         = 16;
    localparam int LEVEL_W   = 4;
    localparam int SEG_W     = 128;
    localparam int NSEG      = HV_DIM / SEG_W;
    localparam int SCORE_W   = $clog2(HV_DIM + 1);
    localparam int SEG_CNT_W = $clog2(SEG_W + 1);
    localparam int SEG_IDX_W = $clog2(NSEG);

    // Midpoint of a level bin in the 16-bit feature space.
    localparam logic [11:0] RECON_OFFSET = 12'h800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dqtz_state_t;

endpackage

// File: rtl/dqtz_level_decoder_hv_seg_popcount.sv
// rtl/dqtz_level_decoder_hv_seg_popcount.sv - combinational AND + popcount of one HV segment
module hv_seg_popcount
    import dqtz_level_decoder_pkg::*;
(
    input  logic [SEG_W-1:0]     i_a,
    input  logic [SEG_W-1:0]     i_b,
    output logic [SEG_CNT_W-1:0] o_count
);

    localparam int NBYTE = SEG_W / 8;

    logic [SEG_W-1:0]     w_and;
    logic [3:0]           w_byte_cnt [NBYTE];
    logic [SEG_CNT_W-1:0] w_sum;

    assign w_and   = i_a & i_b;
    assign o_count = w_sum;

    // Two-level tree: per-byte counts first, then the byte counts are summed.
    always_comb begin
        w_sum = '0;
        for (int b = 0; b < NBYTE; b++) begin
            w_byte_cnt[b] = '0;
            for (int i = 0; i < 8; i++) begin
                w_byte_cnt[b] = w_byte_cnt[b] + 4'(w_and[b*8 + i]);
            end
            w_sum = w_sum + SEG_CNT_W'(w_byte_cnt[b]);
        end
    end

endmodule

// File: rtl/dqtz_level_decoder.sv
// rtl/dqtz_level_decoder.sv - segment-serial best-overlap search over the level item memory
module dqtz_level_decoder
    import dqtz_level_decoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic                       start_decode,
    input  logic [HV_DIM-1:0]          query_hv,
    input  logic [M-1:0][HV_DIM-1:0]   im_hvs,
    output logic                       busy,
    output logic                       decode_done,
    output logic [LEVEL_W-1:0]         level_out,
    output logic [15:0]                value_out,
    output logic [SCORE_W-1:0]         best_score
);

    dqtz_state_t          r_state;
    dqtz_state_t          w_next_state;
    logic [HV_DIM-1:0]    r_query;
    logic [LEVEL_W-1:0]   r_lvl_ctr;
    logic [SEG_IDX_W-1:0] r_seg_ctr;
    logic [SCORE_W-1:0]   r_acc;
    logic [SCORE_W-1:0]   r_best;
    logic [LEVEL_W-1:0]   r_best_lvl;
    logic                 r_decode_done;
    logic [LEVEL_W-1:0]   r_level_out;
    logic [15:0]          r_value_out;
    logic [SCORE_W-1:0]   r_best_score;

    logic [SEG_W-1:0]     w_q_seg;
    logic [SEG_W-1:0]     w_im_seg;
    logic [SEG_CNT_W-1:0] w_seg_cnt;
    logic [SCORE_W-1:0]   w_acc_next;
    logic                 w_last_seg;
    logic                 w_last_lvl;
    logic                 w_take;
    logic                 w_busy;

    assign w_q_seg    = r_query[r_seg_ctr*SEG_W +: SEG_W];
    assign w_im_seg   = im_hvs[r_lvl_ctr][r_seg_ctr*SEG_W +: SEG_W];
    assign w_acc_next = r_acc + SCORE_W'(w_seg_cnt);
    assign w_last_seg = (r_seg_ctr == SEG_IDX_W'(NSEG - 1));
    assign w_last_lvl = (r_lvl_ctr == LEVEL_W'(M - 1));
    // Level 0 always seeds the best; later levels must strictly beat it, so ties keep the lowest index.
    assign w_take     = (r_lvl_ctr == '0) || (w_acc_next > r_best);

    hv_seg_popcount u_seg_popcount (
        .i_a     (w_q_seg),
        .i_b     (w_im_seg),
        .o_count (w_seg_cnt)
    );

    // State register; a low enable freezes the FSM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else if (en) begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, leave SCAN after the final segment of the final level.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_decode) w_next_state = SCAN;
            SCAN:    if (w_last_seg && w_last_lvl) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: busy covers every non-idle state.
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // Scan datapath and result registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_query       <= '0;
            r_lvl_ctr     <= '0;
            r_seg_ctr     <= '0;
            r_acc         <= '0;
            r_best        <= '0;
            r_best_lvl    <= '0;
            r_decode_done <= 1'b0;
            r_level_out   <= '0;
            r_value_out   <= '0;
            r_best_score  <= '0;
        end else if (en) begin
            r_decode_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_decode) begin
                        r_query    <= query_hv;
                        r_lvl_ctr  <= '0;
                        r_seg_ctr  <= '0;
                        r_acc      <= '0;
                        r_best     <= '0;
                        r_best_lvl <= '0;
                    end
                end
                SCAN: begin
                    if (!w_last_seg) begin
                        r_seg_ctr <= r_seg_ctr + SEG_IDX_W'(1);
                        r_acc     <= w_acc_next;
                    end else begin
                        if (w_take) begin
                            r_best     <= w_acc_next;
                            r_best_lvl <= r_lvl_ctr;
                        end
                        r_acc     <= '0;
                        r_seg_ctr <= '0;
                        r_lvl_ctr <= r_lvl_ctr + LEVEL_W'(1);
                    end
                end
                DONE: begin
                    r_decode_done <= 1'b1;
                    r_level_out   <= r_best_lvl;
                    r_value_out   <= {r_best_lvl, RECON_OFFSET};
                    r_best_score  <= r_best;
                end
                default: ;
            endcase
        end
    end

    assign busy        = w_busy;
    assign decode_done = r_decode_done;
    assign level_out   = r_level_out;
    assign value_out   = r_value_out;
    assign best_score  = r_best_score;

endmodule

// File: tb/tb_dqtz_level_decoder.sv
// tb/tb_dqtz_level_decoder.sv - self-checking bench for dqtz_level_decoder
module tb_dqtz_level_decoder;
    import dqtz_level_decoder_pkg::*;

    localparam int LAT = M * NSEG + 1;

    logic                     clk = 1'b0;
    logic                     nrst = 1'b0;
    logic                     en = 1'b1;
    logic                     start_decode = 1'b0;
    logic [HV_DIM-1:0]        query_hv = '0;
    logic [M-1:0][HV_DIM-1:0] im_hvs;
    logic                     busy;
    logic                     decode_done;
    logic [LEVEL_W-1:0]       level_out;
    logic [15:0]              value_out;
    logic [SCORE_W-1:0]       best_score;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_acc = 0;
    int exp_done_cyc = 0;
    int exp_lvl = 0;
    int exp_score = 0;
    bit exp_pending = 1'b0;
    int n_done = 0;
    int n_expected_done = 0;

    dqtz_level_decoder dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .start_decode (start_decode),
        .query_hv     (query_hv),
        .im_hvs       (im_hvs),
        .busy         (busy),
        .decode_done  (decode_done),
        .level_out    (level_out),
        .value_out    (value_out),
        .best_score   (best_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: score every level over the whole HV, keep the first strict maximum.
    task automatic model(input logic [HV_DIM-1:0] q, output int lvl, output int sc);
        int s;
        lvl = 0;
        sc  = -1;
        for (int l = 0; l < M; l++) begin
            s = $countones(q & im_hvs[l]);
            if (s > sc) begin
                sc  = s;
                lvl = l;
            end
        end
    endtask

    task automatic pin_model(input string name, input logic [HV_DIM-1:0] q,
                             input int lit_lvl, input int lit_score);
        int l, s;
        model(q, l, s);
        chk({name, "_model_lvl"}, l, lit_lvl);
        chk({name, "_model_score"}, s, lit_score);
    endtask

    // Compare process: every cycle of a pending decode, busy and the result pulse are checked.
    always @(negedge clk) begin
        if (nrst) begin
            if (exp_pending && cyc >= t_acc && cyc < exp_done_cyc)
                chk("busy_during_scan", busy, 1);
            if (decode_done) begin
                if (!exp_pending) begin
                    chk("unexpected_done", decode_done, 0);
                end else begin
                    chk("done_cycle", cyc, exp_done_cyc);
                    chk("level_out", level_out, exp_lvl);
                    chk("value_out", value_out, {exp_lvl[3:0], 12'h800});
                    chk("best_score", best_score, exp_score);
                    chk("busy_at_done", busy, 0);
                    n_done++;
                    exp_pending = 1'b0;
                end
            end
        end
    end

    task automatic start_one(input logic [HV_DIM-1:0] q, input int stall_len);
        @(negedge clk);
        query_hv     = q;
        start_decode = 1'b1;
        t_acc        = cyc + 1;
        model(q, exp_lvl, exp_score);
        exp_done_cyc = t_acc + LAT + stall_len;
        exp_pending  = 1'b1;
        n_expected_done++;
        @(negedge clk);
        start_decode = 1'b0;
        query_hv     = ~q;
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (exp_pending && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (exp_pending) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no decode_done within %0d cycles", name, guard);
            exp_pending = 1'b0;
        end
    endtask

    task automatic run_decode(input string name, input logic [HV_DIM-1:0] q,
                              input int stall_at, input int stall_len, input bit stray);
        start_one(q, stall_len);
        if (stall_len > 0) begin
            repeat (stall_at) @(negedge clk);
            en = 1'b0;
            repeat (stall_len) @(negedge clk);
            en = 1'b1;
        end
        if (stray) begin
            repeat (5) @(negedge clk);
            query_hv     = ~q;
            start_decode = 1'b1;
            @(negedge clk);
            start_decode = 1'b0;
        end
        wait_done(name);
    endtask

    function automatic logic [HV_DIM-1:0] rand_sparse();
        logic [HV_DIM-1:0] v;
        for (int w = 0; w < HV_DIM / 32; w++)
            v[w*32 +: 32] = $urandom() & $urandom() & $urandom();
        return v;
    endfunction

    initial begin
        logic [HV_DIM-1:0] q;
        int mode, lvl_pick;

        // Disjoint interleaved item memory: 64 ones per level, 8 in every segment.
        im_hvs = '0;
        for (int l = 0; l < M; l++)
            for (int k = 0; k < 64; k++)
                im_hvs[l][k*16 + l] = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", decode_done, 0);
        chk("rst_level", level_out, 0);
        chk("rst_value", value_out, 0);
        chk("rst_score", best_score, 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Exact match on level 5.
        pin_model("exact5", im_hvs[5], 5, 64);
        run_decode("exact5", im_hvs[5], 0, 0, 1'b0);
        chk("exact5_value_lit", value_out, 16'h5800);
        chk("exact5_score_lit", best_score, 64);

        // Equal overlap with levels 3 and 9: lowest index wins.
        q = im_hvs[3] | im_hvs[9];
        pin_model("tie39", q, 3, 64);
        run_decode("tie39", q, 0, 0, 1'b0);
        chk("tie39_level_lit", level_out, 3);
        chk("tie39_value_lit", value_out, 16'h3800);

        // All-zero query.
        pin_model("zero", '0, 0, 0);
        run_decode("zero", '0, 0, 0, 1'b0);
        chk("zero_value_lit", value_out, 16'h0800);
        chk("zero_score_lit", best_score, 0);

        // 10-cycle stall mid-scan plus an ignored start while busy.
        run_decode("stall15", im_hvs[15], 40, 10, 1'b1);
        chk("stall15_level_lit", level_out, 15);
        chk("stall15_value_lit", value_out, 16'hF800);
        chk("stall15_latency_lit", exp_done_cyc - t_acc, 139);
        repeat (20) @(negedge clk);

        // Reset 60 cycles into a scan discards the partial result.
        start_one(im_hvs[12], 0);
        while (cyc < t_acc + 60) @(negedge clk);
        #2 nrst = 1'b0;
        exp_pending = 1'b0;
        n_expected_done--;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", decode_done, 0);
        chk("midrst_level", level_out, 0);
        chk("midrst_value", value_out, 0);
        chk("midrst_score", best_score, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        run_decode("after_rst7", im_hvs[7], 0, 0, 1'b0);
        chk("after_rst7_level_lit", level_out, 7);

        // Random regression, some with noise around a real level, some with stalls.
        for (int n = 0; n < 200; n++) begin
            mode     = $urandom_range(0, 2);
            lvl_pick = $urandom_range(0, M - 1);
            q = rand_sparse();
            if (mode == 1) q = q | im_hvs[lvl_pick];
            if (mode == 2) q = q & ~im_hvs[lvl_pick];
            if ($urandom_range(0, 4) == 0)
                run_decode("rand", q, $urandom_range(1, 100), $urandom_range(1, 6), 1'b0);
            else
                run_decode("rand", q, 0, 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("done_count", n_done, n_expected_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
